seg7_scan: RTL and testbench
============================

// Module: seg7_scan
// PURPOSE
//   Display stage downstream of the BCD time counters (count_6 / mod-10 chain).
//   Time-multiplexes NUM_DIG BCD digits onto one common 7-segment bus with
//   active-low anode selects. Adds leading-zero blanking, per-digit blink for
//   set mode, decimal points and a dead-time slot to suppress ghosting.
// PARAMETERS
//   NUM_DIG    6      number of digits scanned (>=2)
//   SCAN_DIV   50000  clk cycles each digit is selected (>=2)
//   BLINK_DIV  64     digit slots per blink half-period (>=1)
// PORTS
//   clk        in   1          system clock, all logic on posedge
//   rst        in   1          synchronous, active-high reset
//   digits     in   4*NUM_DIG  packed BCD; digits[3:0]=digit 0 (LSD), top nibble=MSD
//   dp_mask    in   NUM_DIG    1 = light decimal point of that digit
//   blank_lz   in   1          1 = enable leading-zero blanking
//   blink_mask in   NUM_DIG    1 = digit blinks (off during blink-off phase)
//   an         out  NUM_DIG    anode selects, active low, one-hot-low or all 1
//   seg        out  7          {g,f,e,d,c,b,a}, active low
//   dp         out  1          decimal point, active low
// BEHAVIOUR
//   - Reset (synchronous, active-high): an=all 1, seg=7'h7F, dp=1, slot counter=0,
//     digit index=0, blink phase=0, snapshot=0. Reset mid-scan takes effect on the
//     next edge, overriding everything; no partial frame after release.
//   - Slot counter cnt: 0..SCAN_DIV-1, wraps; width $clog2(SCAN_DIV).
//   - On wrap (cnt==SCAN_DIV-1): idx <= (idx==NUM_DIG-1) ? 0 : idx+1; digits,
//     dp_mask, blank_lz and blink_mask snapshotted in the same edge. Changes to
//     inputs inside a slot are ignored until the next wrap (no tearing).
//   - Dead time: on the cycle with cnt==0 all outputs are off (an all 1,
//     seg=7'h7F, dp=1). For cnt 1..SCAN_DIV-1 an[idx]=0, others 1.
//   - All outputs registered; the data shown in a slot is from the snapshot taken
//     at its start, outputs valid from cnt==1 onward.
//   - Decode: 0..9 standard glyphs (0=7'h40, 1=7'h79, 2=7'h24, 4=7'h19);
//     codes 10..15 show dash (7'h3F, g only).
//   - Leading-zero blank: when blank_lz=1, digit k (k>=1) is blanked (seg=7'h7F,
//     an still driven) iff all snapshot nibbles k..NUM_DIG-1 are 0. Digit 0 never
//     blanked. Dp unaffected by blanking.
//   - Blink: phase toggles every BLINK_DIV index advances; while phase=1 a digit
//     with blink_mask bit set shows seg=7'h7F, dp=1 (anode still driven).
//   - Blink and LZ blanking are OR-ed; decoder result only used when neither.
// STRUCTURE
//   - seg7_pkg: glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (7'h7F).
//   - Sub-module bcd_to_seg7: combinational 4-bit -> 7-bit active-low decoder.
//   - Top: slot counter, index, blink-phase counter, snapshot regs, output regs.
// TESTING  (bench uses SCAN_DIV=4, BLINK_DIV=2, NUM_DIG=6)
//   - rst held 3 cycles mid-scan -> next edge an=6'h3F, seg=7'h7F, dp=1; after
//     release first lit slot is digit 0 on cycle cnt==1.
//   - digits=24'h654321, blank_lz=0 -> an sequence 3E,3D,3B,37,2F,1F, each lit 3
//     cycles with 1 all-off cycle between; digit 0 seg=7'h79.
//   - digits=24'h000042, blank_lz=1 -> digits 5..2 seg=7'h7F, digit1=7'h19,
//     digit0=7'h24; digits=0 -> only digit 0 shows 7'h40.
//   - digit 3 nibble=4'hA -> seg=7'h3F in slot 3; dp_mask=6'b000100 -> dp=0
//     only in slot 2.
//   - blink_mask=6'b000011 -> digits 0,1 dark for 2 slots, lit for 2, repeating;
//     other digits unaffected.
//   - change digits at cnt==2 of slot 1 -> slot 1 output unchanged, new value
//     appears from next slot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared glyph constants for the 7-segment scan display.
// Encoding is {g,f,e,d,c,b,a}, active low (0 = segment lit).
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-low segments.
// Non-decimal codes render as a single dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Glyph lookup; codes 10..15 fall through to the dash
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: one digit per slot, dead cycle at slot
// start, leading-zero blanking, per-digit blink and decimal points.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIG   = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   digits,
    input  logic [NUM_DIG-1:0]     dp_mask,
    input  logic                   blank_lz,
    input  logic [NUM_DIG-1:0]     blink_mask,
    output logic [NUM_DIG-1:0]     an,
    output logic [6:0]             seg,
    output logic                   dp
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIG);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BLK_W-1:0]     bcnt_q, bcnt_d;
    logic                 phase_q, phase_d;
    logic [4*NUM_DIG-1:0] dig_q, dig_d;
    logic [NUM_DIG-1:0]   dpm_q, dpm_d;
    logic [NUM_DIG-1:0]   blm_q, blm_d;
    logic                 blz_q, blz_d;
    logic [NUM_DIG-1:0]   an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic                 wrap;
    logic [3:0]           nib;
    logic [6:0]           glyph;
    logic [NUM_DIG-1:0]   upz;
    logic                 lz;
    logic                 blk;
    logic                 dead;

    // Slot timing, digit index, blink phase and slot-start snapshot
    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        dig_d   = dig_q;
        dpm_d   = dpm_q;
        blm_d   = blm_q;
        blz_d   = blz_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (bcnt_q == BLK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BLK_W'(1);
            end
            dig_d = digits;
            dpm_d = dp_mask;
            blm_d = blink_mask;
            blz_d = blank_lz;
        end
    end

    // upz[k]: every snapshot nibble from k up to the MSD is zero
    for (genvar k = 0; k < NUM_DIG; k++) begin : g_upz
        assign upz[k] = (dig_d[4*NUM_DIG-1:4*k] == '0);
    end

    assign nib = dig_d[{idx_d, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd_i (nib),
        .seg_o (glyph)
    );

    // Next output values, aligned with the slot the counters move into
    always_comb begin
        dead = (cnt_d == '0);
        lz   = blz_d && (idx_d != '0) && upz[idx_d];
        blk  = phase_d && blm_d[idx_d];
        an_d = ~(NUM_DIG'(1) << idx_d);
        seg_d = glyph;
        dp_d  = ~dpm_d[idx_d];
        if (lz || blk) begin
            seg_d = SEG_OFF;
        end
        if (blk) begin
            dp_d = 1'b1;
        end
        if (dead) begin
            an_d  = '1;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    // State and registered outputs; reset dominates everything
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            dig_q   <= '0;
            dpm_q   <= '0;
            blm_q   <= '0;
            blz_q   <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            dig_q   <= dig_d;
            dpm_q   <= dpm_d;
            blm_q   <= blm_d;
            blz_q   <= blz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with a slot-arithmetic reference model.
// Inputs change on negedge; outputs are compared on negedge.
module tb_seg7_scan;

    localparam int ND = 6;
    localparam int SD = 4;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] digits = '0;
    logic [5:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [5:0]  blink_mask = '0;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int vec = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seg7_scan #(
        .NUM_DIG   (ND),
        .SCAN_DIV  (SD),
        .BLINK_DIV (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    // Reference state: cycles since reset and the slot-start snapshot
    int          t = 0;
    logic [23:0] s_dig = '0;
    logic [5:0]  s_dp = '0;
    logic [5:0]  s_blk = '0;
    logic        s_blz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t     <= 0;
            s_dig <= '0;
            s_dp  <= '0;
            s_blk <= '0;
            s_blz <= 1'b0;
        end else begin
            t <= t + 1;
            if ((t + 1) % SD == 0) begin
                s_dig <= digits;
                s_dp  <= dp_mask;
                s_blk <= blink_mask;
                s_blz <= blank_lz;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {an, seg, dp} for the current cycle
    function automatic logic [13:0] expv();
        int n;
        int k;
        logic lz;
        logic bl;
        logic [6:0] s;
        logic d;
        logic [5:0] a;
        if (t % SD == 0) return {6'h3F, 7'h7F, 1'b1};
        n  = t / SD;
        k  = n % ND;
        lz = s_blz && (k >= 1) && ((s_dig >> (4 * k)) == 24'd0);
        bl = ((n / BD) % 2 == 1) && s_blk[k];
        s  = (lz || bl) ? 7'h7F : glyph(s_dig[4*k +: 4]);
        d  = bl ? 1'b1 : ~s_dp[k];
        a  = ~(6'b1 << k);
        return {a, s, d};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        digits = 24'h654321;
        do_reset();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vec++;
            if ({an, seg, dp} !== {6'h3F, 7'h7F, 1'b1}) begin
                bad++;
                $display("FAIL reset_hold got an=%h seg=%h dp=%b want 3f 7f 1",
                         an, seg, dp);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({an, seg, dp} !== {6'h3E, 7'h40, 1'b1}) begin
            bad++;
            $display("FAIL reset_first got an=%h seg=%h dp=%b want 3e 40 1",
                     an, seg, dp);
        end
        repeat (12) begin
            @(negedge clk);
            vec++;
            if ({an, seg, dp} !== expv()) begin
                bad++;
                $display("FAIL reset_model t=%0d got %h want %h",
                         t, {an, seg, dp}, expv());
            end
        end
    endtask

    task automatic test_scan_order();
        logic [5:0] ans [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        digits   = 24'h654321;
        blank_lz = 1'b0;
        do_reset();
        repeat (30) begin
            @(negedge clk);
            vec++;
            if ({an, seg, dp} !== expv()) begin
                bad++;
                $display("FAIL scan_model t=%0d got %h want %h",
                         t, {an, seg, dp}, expv());
            end
            if (t % SD == 1) begin
                vec++;
                if (an !== ans[(t / SD) % ND]) begin
                    bad++;
                    $display("FAIL scan_order t=%0d got an=%h want %h",
                             t, an, ans[(t / SD) % ND]);
                end
            end
            if (t / SD == 6 && t % SD != 0) begin
                vec++;
                if (seg !== 7'h79) begin
                    bad++;
                    $display("FAIL scan_dig0 t=%0d got seg=%h want 79", t, seg);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] w;
        digits   = 24'h000042;
        blank_lz = 1'b1;
        do_reset();
        repeat (56) begin
            @(negedge clk);
            if (t == 28) digits = 24'h000000;
            vec++;
            if ({an, seg, dp} !== expv()) begin
                bad++;
                $display("FAIL lz_model t=%0d got %h want %h",
                         t, {an, seg, dp}, expv());
            end
            if (t % SD != 0 && t / SD >= 6 && t / SD != 7) begin
                if (t / SD < 8)
                    w = ((t / SD) % ND == 0) ? 7'h24 : 7'h7F;
                else
                    w = ((t / SD) % ND == 0) ? 7'h40 : 7'h7F;
                if (t / SD < 8 && (t / SD) % ND == 1) w = 7'h19;
                if (t / SD >= 6 && t / SD < 12) begin
                    vec++;
                    if (seg !== w) begin
                        bad++;
                        $display("FAIL lz_seg t=%0d got seg=%h want %h", t, seg, w);
                    end
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_dash_dp();
        int k;
        digits  = 24'h12A456;
        dp_mask = 6'b000100;
        do_reset();
        repeat (52) begin
            @(negedge clk);
            vec++;
            if ({an, seg, dp} !== expv()) begin
                bad++;
                $display("FAIL dashdp_model t=%0d got %h want %h",
                         t, {an, seg, dp}, expv());
            end
            k = (t / SD) % ND;
            if (t / SD >= 6 && t % SD != 0) begin
                vec++;
                if (dp !== (k != 2)) begin
                    bad++;
                    $display("FAIL dp_slot t=%0d got dp=%b want %b", t, dp, k != 2);
                end
                if (k == 3) begin
                    vec++;
                    if (seg !== 7'h3F) begin
                        bad++;
                        $display("FAIL dash t=%0d got seg=%h want 3f", t, seg);
                    end
                end
            end
        end
        dp_mask = '0;
    endtask

    task automatic test_blink();
        digits     = 24'h654321;
        blink_mask = 6'b000011;
        dp_mask    = 6'b000011;
        do_reset();
        repeat (100) begin
            @(negedge clk);
            vec++;
            if ({an, seg, dp} !== expv()) begin
                bad++;
                $display("FAIL blink_model t=%0d got %h want %h",
                         t, {an, seg, dp}, expv());
            end
            if (t / SD >= 6 && (t / SD) % ND == 2 && t % SD != 0) begin
                vec++;
                if (seg !== 7'h30) begin
                    bad++;
                    $display("FAIL blink_other t=%0d got seg=%h want 30", t, seg);
                end
            end
        end
        blink_mask = '0;
        dp_mask    = '0;
    endtask

    task automatic test_tearing();
        digits = 24'h111111;
        do_reset();
        repeat (16) begin
            @(negedge clk);
            vec++;
            if ({an, seg, dp} !== expv()) begin
                bad++;
                $display("FAIL tear_model t=%0d got %h want %h",
                         t, {an, seg, dp}, expv());
            end
            if (t % SD != 0 && (t / SD == 1 || t / SD == 2)) begin
                vec++;
                if (seg !== ((t / SD == 1) ? 7'h79 : 7'h10)) begin
                    bad++;
                    $display("FAIL tear_seg t=%0d got seg=%h want %h",
                             t, seg, (t / SD == 1) ? 7'h79 : 7'h10);
                end
            end
            if (t == 6) digits = 24'h999999;
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (600) begin
            @(negedge clk);
            vec++;
            if ({an, seg, dp} !== expv()) begin
                bad++;
                $display("FAIL rand_model t=%0d rst=%b got %h want %h",
                         t, rst, {an, seg, dp}, expv());
            end
            if ($urandom_range(0, 2) == 0) digits = 24'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                digits = digits & 24'h00FF0F;
            end
            if ($urandom_range(0, 4) == 0) dp_mask = 6'($urandom);
            if ($urandom_range(0, 4) == 0) blink_mask = 6'($urandom);
            if ($urandom_range(0, 6) == 0) blank_lz = 1'($urandom);
            rst = ($urandom_range(0, 60) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_lz();
        test_dash_dp();
        test_blink();
        test_tearing();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
